// File: rtl/jr_redirect_unit_if.sv
// jr_redirect_unit_if
// Groups the ID-stage jump-register signals between the pipeline control
// (master) and the jump-register redirect unit (slave).
//   i_valid/i_jr/i_jalr     : instruction qualifiers from the decoder
//   i_rs_data/i_rs_hazard   : forwarded rs value and its not-yet-ready flag
//   i_pc_plus4/i_rd_addr    : return-address base and link destination
//   i_stall_ext/i_flush     : global stall and kill-from-older-instruction
//   o_stall_id              : hold PC/IF/ID while rs is pending
//   o_pc_redirect/o_target  : PC load request and jump target
//   o_flush_if              : squash the IF/ID instruction
//   o_link_we/addr/data     : JALR link-register writeback request
//   o_wait_cycles           : rs-wait cycles of the last completed JR
//   o_misaligned            : misaligned-target exception pulse
interface jr_redirect_unit_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
);
    logic              i_valid;
    logic              i_jr;
    logic              i_jalr;
    logic [DATA_W-1:0] i_rs_data;
    logic              i_rs_hazard;
    logic [DATA_W-1:0] i_pc_plus4;
    logic [4:0]        i_rd_addr;
    logic              i_stall_ext;
    logic              i_flush;
    logic              o_stall_id;
    logic              o_pc_redirect;
    logic [DATA_W-1:0] o_target;
    logic              o_flush_if;
    logic              o_link_we;
    logic [4:0]        o_link_addr;
    logic [DATA_W-1:0] o_link_data;
    logic [CNT_W-1:0]  o_wait_cycles;
    logic              o_misaligned;

    modport master (
        output i_valid, i_jr, i_jalr, i_rs_data, i_rs_hazard, i_pc_plus4,
               i_rd_addr, i_stall_ext, i_flush,
        input  o_stall_id, o_pc_redirect, o_target, o_flush_if, o_link_we,
               o_link_addr, o_link_data, o_wait_cycles, o_misaligned
    );

    modport slave (
        input  i_valid, i_jr, i_jalr, i_rs_data, i_rs_hazard, i_pc_plus4,
               i_rd_addr, i_stall_ext, i_flush,
        output o_stall_id, o_pc_redirect, o_target, o_flush_if, o_link_we,
               o_link_addr, o_link_data, o_wait_cycles, o_misaligned
    );
endinterface

// File: rtl/jr_redirect_unit.sv
// jr_redirect_unit
// Resolves JR/JALR in the ID stage: stalls ID while rs is not forwardable,
// then issues a one-cycle PC redirect (plus IF flush when there is no delay
// slot) and, for JALR, a link-register write request.
// Ports:
//   i_clk      : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   bus        : jr_redirect_unit_if slave modport (see interface header)
// Optional build macro JR_MISALIGN_TRAP_EN: a captured target with nonzero
// low bits raises o_misaligned instead of redirecting. Without it the low
// two target bits are forced to 00 and the redirect proceeds.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | no JR in flight; accept a new JR when not stalled/flushed
// S_WAIT_RS  | JR captured, rs pending; ID stalled, counting wait cycles
// S_REDIRECT | target known; redirect/link outputs driven from registers
module jr_redirect_unit #(
    parameter int DATA_W     = 32,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 4
) (
    input logic          i_clk,
    input logic          i_reset_n,
    jr_redirect_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RS  = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] LINK_OFS = (DELAY_SLOT != 0) ? DATA_W'(8) - DATA_W'(4) : '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic              NO_SLOT  = (DELAY_SLOT == 0);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] link_data_q, link_data_d;
    logic [4:0]        link_addr_q, link_addr_d;
    logic              jalr_q, jalr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    logic req;
    logic mis;
    logic stall_id;
    logic redirect;
    logic misaligned;
    logic flush_if;
    logic link_we;

    assign req = bus.i_valid & bus.i_jr;

`ifdef JR_MISALIGN_TRAP_EN
    assign mis = (target_q[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        link_data_d = link_data_q;
        link_addr_d = link_addr_q;
        jalr_d      = jalr_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        stall_id    = 1'b0;
        redirect    = 1'b0;
        misaligned  = 1'b0;
        flush_if    = 1'b0;
        link_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.i_flush && req && !bus.i_stall_ext) begin
                    link_addr_d = bus.i_rd_addr;
                    jalr_d      = bus.i_jalr;
                    link_data_d = bus.i_pc_plus4 + LINK_OFS;
                    if (bus.i_rs_hazard) begin
                        // The first hazard cycle is already counted here.
                        cnt_d    = CNT_W'(1);
                        stall_id = 1'b1;
                        state_d  = S_WAIT_RS;
                    end else begin
                        target_d = bus.i_rs_data;
                        cnt_d    = '0;
                        state_d  = S_REDIRECT;
                    end
                end
            end

            S_WAIT_RS: begin
                stall_id = 1'b1;
                if (bus.i_flush) begin
                    state_d     = S_IDLE;
                    target_d    = '0;
                    link_data_d = '0;
                    link_addr_d = '0;
                    jalr_d      = 1'b0;
                    cnt_d       = '0;
                end else if (bus.i_rs_hazard) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!bus.i_stall_ext) begin
                    // Release ID in the same cycle the target is captured.
                    target_d = bus.i_rs_data;
                    stall_id = 1'b0;
                    state_d  = S_REDIRECT;
                end
            end

            S_REDIRECT: begin
                if (!bus.i_flush) begin
                    redirect   = !mis;
                    misaligned = mis;
                    flush_if   = mis | NO_SLOT;
                    link_we    = jalr_q & (link_addr_q != 5'd0) & !mis;
                end
                if (bus.i_flush || !bus.i_stall_ext) begin
                    state_d     = S_IDLE;
                    wait_d      = cnt_q;
                    target_d    = '0;
                    link_data_d = '0;
                    link_addr_d = '0;
                    jalr_d      = 1'b0;
                    cnt_d       = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            link_data_q <= '0;
            link_addr_q <= '0;
            jalr_q      <= 1'b0;
            cnt_q       <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            link_data_q <= link_data_d;
            link_addr_q <= link_addr_d;
            jalr_q      <= jalr_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
        end
    end

    // The IDLE stall path is combinational from the inputs, so it is gated by
    // reset to keep every output low while reset is held.
    assign bus.o_stall_id    = stall_id & i_reset_n;
    assign bus.o_pc_redirect = redirect;
    assign bus.o_misaligned  = misaligned;
    assign bus.o_flush_if    = flush_if;
    assign bus.o_link_we     = link_we;
    assign bus.o_target      = (state_q != S_REDIRECT) ? '0 :
                               mis ? target_q : {target_q[DATA_W-1:2], 2'b00};
    assign bus.o_link_addr   = (state_q == S_REDIRECT) ? link_addr_q : 5'd0;
    assign bus.o_link_data   = (state_q == S_REDIRECT) ? link_data_q : '0;
    assign bus.o_wait_cycles = wait_q;

endmodule

// File: tb/tb_jr_redirect_unit.sv
module tb_jr_redirect_unit;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
`ifdef JR_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid = 0, jr = 0, jalr = 0, hazard = 0, stall_ext = 0, flush = 0;
    logic [31:0] rs = 0, pc4 = 0;
    logic [4:0]  rd = 0;

    jr_redirect_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus1 ();
    jr_redirect_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus0 ();

    assign bus1.i_valid = valid;     assign bus0.i_valid = valid;
    assign bus1.i_jr = jr;           assign bus0.i_jr = jr;
    assign bus1.i_jalr = jalr;       assign bus0.i_jalr = jalr;
    assign bus1.i_rs_data = rs;      assign bus0.i_rs_data = rs;
    assign bus1.i_rs_hazard = hazard; assign bus0.i_rs_hazard = hazard;
    assign bus1.i_pc_plus4 = pc4;    assign bus0.i_pc_plus4 = pc4;
    assign bus1.i_rd_addr = rd;      assign bus0.i_rd_addr = rd;
    assign bus1.i_stall_ext = stall_ext; assign bus0.i_stall_ext = stall_ext;
    assign bus1.i_flush = flush;     assign bus0.i_flush = flush;

    jr_redirect_unit #(.DATA_W(DATA_W), .DELAY_SLOT(1), .CNT_W(CNT_W)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus1));
    jr_redirect_unit #(.DATA_W(DATA_W), .DELAY_SLOT(0), .CNT_W(CNT_W)) u_dut_ds0 (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus0));

    typedef struct {
        logic [31:0] target;
        bit          mis;
        bit          link_we;
        logic [4:0]  rd;
        logic [31:0] pc4;
        int          waitc;
        int          stall;
        int          cyc;
        int          hold;
        bit          flushed;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor
    int stall_acc = 0, hold_acc = 0, exp_wait = 0, pend_w = 0;
    bit pend_v = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_acc = 0; hold_acc = 0; exp_wait = 0; pend_v = 0;
        end else begin
            if (pend_v) begin exp_wait = pend_w; pend_v = 0; end
            chk("wait_cycles_ds1", 32'(bus1.o_wait_cycles), 32'(exp_wait));
            chk("wait_cycles_ds0", 32'(bus0.o_wait_cycles), 32'(exp_wait));
            if (bus1.o_stall_id) stall_acc++;
            if (flush) begin
                chk("flush_gate_ds1", 32'({bus1.o_pc_redirect, bus1.o_misaligned, bus1.o_flush_if, bus1.o_link_we}), 32'(0));
                chk("flush_gate_ds0", 32'({bus0.o_pc_redirect, bus0.o_misaligned, bus0.o_flush_if, bus0.o_link_we}), 32'(0));
            end
            if (sbq.size() > 0 && sbq[0].flushed && cyc == sbq[0].cyc) begin
                pend_w = sbq[0].waitc; pend_v = 1;
                void'(sbq.pop_front());
                hold_acc = 0;
            end else if (bus1.o_pc_redirect || bus1.o_misaligned) begin
                if (sbq.size() == 0 || sbq[0].flushed) begin
                    checks++; errors++;
                    $display("FAIL spurious_redirect actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = sbq[0];
                    hold_acc++;
                    chk("redirect_ds1", 32'(bus1.o_pc_redirect), 32'(!e.mis));
                    chk("misaligned_ds1", 32'(bus1.o_misaligned), 32'(e.mis));
                    chk("target_ds1", bus1.o_target, e.target);
                    chk("flush_if_ds1", 32'(bus1.o_flush_if), 32'(e.mis));
                    chk("link_we_ds1", 32'(bus1.o_link_we), 32'(e.link_we));
                    chk("link_addr_ds1", 32'(bus1.o_link_addr), 32'(e.rd));
                    chk("link_data_ds1", bus1.o_link_data, e.pc4 + 32'd4);
                    chk("redirect_ds0", 32'(bus0.o_pc_redirect), 32'(!e.mis));
                    chk("flush_if_ds0", 32'(bus0.o_flush_if), 32'(1));
                    chk("link_we_ds0", 32'(bus0.o_link_we), 32'(e.link_we));
                    chk("link_data_ds0", bus0.o_link_data, e.pc4);
                    if (!stall_ext) begin
                        chk("redirect_cycle", 32'(cyc), 32'(e.cyc));
                        chk("redirect_hold", 32'(hold_acc), 32'(e.hold));
                        chk("stall_id_cycles", 32'(stall_acc), 32'(e.stall));
                        pend_w = e.waitc; pend_v = 1;
                        void'(sbq.pop_front());
                        hold_acc = 0; stall_acc = 0;
                    end
                end
            end else begin
                chk("link_we_idle", 32'({bus1.o_link_we, bus0.o_link_we}), 32'(0));
            end
            if (flush) stall_acc = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'($urandom_range(0, 1)); jr = 0; jalr = 1'($urandom_range(0, 1));
            hazard = 1'($urandom_range(0, 1)); stall_ext = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 7) == 0);
            rs = $urandom; pc4 = $urandom; rd = 5'($urandom);
            tick();
        end
        valid = 0; jalr = 0; hazard = 0; stall_ext = 0; flush = 0;
    endtask

    // mode 0: normal, 1: flush while waiting for rs (haz >= 1), 2: flush in redirect
    task automatic do_jr(bit jalr_i, logic [4:0] rd_i, logic [31:0] rs_i, logic [31:0] pc4_i,
                         int haz, int pre_stall, int wait_stall, int red_stall, int mode);
        exp_t e;
        bit   m;
        valid = 1; jr = 1; jalr = jalr_i; rd = rd_i; pc4 = pc4_i; flush = 0;
        for (int i = 0; i < pre_stall; i++) begin
            stall_ext = 1; hazard = 1'($urandom_range(0, 1)); rs = $urandom;
            tick();
        end
        stall_ext = 0;
        if (haz > 0) begin
            hazard = 1; rs = $urandom;
            tick();
            if (mode == 1) begin
                flush = 1; hazard = 1;
                tick();
                flush = 0; valid = 0; jr = 0; hazard = 0;
                return;
            end
            for (int i = 1; i < haz; i++) tick();
            hazard = 0;
            for (int i = 0; i < wait_stall; i++) begin stall_ext = 1; tick(); end
            stall_ext = 0;
        end
        hazard = 0; rs = rs_i;
        m = MIS_EN && (rs_i[1:0] != 2'b00);
        e.mis     = m;
        e.target  = m ? rs_i : (rs_i & ~32'h3);
        e.link_we = jalr_i && (rd_i != 5'd0) && !m;
        e.rd      = rd_i;
        e.pc4     = pc4_i;
        e.waitc   = (haz > 15) ? 15 : haz;
        e.stall   = (haz > 0) ? haz + wait_stall : 0;
        e.flushed = (mode == 2);
        e.hold    = red_stall + 1;
        e.cyc     = cyc + 1 + ((mode == 2) ? 0 : red_stall);
        sbq.push_back(e);
        tick();
        valid = 0; jr = 0; rs = $urandom;
        if (mode == 2) begin
            flush = 1; tick(); flush = 0;
        end else begin
            for (int i = 0; i < red_stall; i++) begin stall_ext = 1; tick(); end
            stall_ext = 0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int haz, mode, rstall;
        logic [31:0] r;
        #3;
        chk("reset_outputs_ds1", 32'({bus1.o_stall_id, bus1.o_pc_redirect, bus1.o_flush_if, bus1.o_link_we,
                                      bus1.o_misaligned, bus1.o_wait_cycles}), 32'(0));
        chk("reset_target", bus1.o_target | bus1.o_link_data | 32'(bus1.o_link_addr), 32'(0));
        tick(); tick();
        rst_n = 1;
        tick();

        do_jr(0, 5'd4, 32'h0040_0100, 32'h0000_2000, 0, 0, 0, 0, 0);  idle_cycles(2);
        do_jr(1, 5'd31, 32'h0040_0200, 32'h0000_1004, 0, 0, 0, 0, 0); idle_cycles(2);
        do_jr(0, 5'd2, 32'h0000_8000, 32'h0000_3000, 3, 0, 0, 0, 0);  idle_cycles(2);
        do_jr(1, 5'd0, 32'h1234_5678, 32'h0000_4000, 0, 1, 0, 0, 0);  idle_cycles(2);
        do_jr(0, 5'd3, 32'h0001_0000, 32'h0000_5000, 0, 0, 0, 2, 0);  idle_cycles(2);
        do_jr(1, 5'd7, 32'h0002_0000, 32'h0000_6000, 3, 0, 0, 0, 1);  idle_cycles(2);
        do_jr(1, 5'd7, 32'h0003_0000, 32'h0000_7000, 0, 0, 0, 0, 2);  idle_cycles(2);
        do_jr(1, 5'd9, 32'h0040_0102, 32'h0000_8000, 0, 0, 0, 0, 0);  idle_cycles(2);
        do_jr(0, 5'd1, 32'h0004_0000, 32'h0000_9000, 20, 0, 1, 0, 0); idle_cycles(2);

        // Reset in the middle of an rs wait.
        valid = 1; jr = 1; jalr = 1; rd = 5'd5; hazard = 1; stall_ext = 0;
        tick(); tick();
        #2 rst_n = 0;
        #1;
        chk("async_reset_ds1", 32'({bus1.o_stall_id, bus1.o_pc_redirect, bus1.o_flush_if, bus1.o_link_we,
                                    bus1.o_misaligned, bus1.o_wait_cycles}), 32'(0));
        chk("async_reset_ds0", 32'({bus0.o_stall_id, bus0.o_pc_redirect, bus0.o_flush_if, bus0.o_link_we,
                                    bus0.o_misaligned, bus0.o_wait_cycles}), 32'(0));
        tick();
        valid = 0; jr = 0; jalr = 0; hazard = 0;
        rst_n = 1;
        tick();

        for (int t = 0; t < 40; t++) begin
            haz = ($urandom_range(0, 9) == 0) ? 18 : int'($urandom_range(0, 4));
            mode = int'($urandom_range(0, 5));
            if (mode > 2 || (mode == 1 && haz == 0)) mode = 0;
            rstall = (mode == 2) ? 0 : int'($urandom_range(0, 2));
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            do_jr(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                  r, $urandom & ~32'h3, haz, int'($urandom_range(0, 2)),
                  (haz > 0) ? int'($urandom_range(0, 1)) : 0, rstall, mode);
            idle_cycles(int'($urandom_range(1, 3)));
        end

        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
